// File: rtl/memory_writer_pkg.sv
// Shared types and helpers for the memory_writer line-to-burst frame writer.
package memory_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        BURST,
        DONE
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // AXI size encoding: log2 of the beat width in bytes.
    function automatic logic [2:0] size_from_width(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/memory_writer_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module memory_writer_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the array still maps to block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_writer.sv
// Buffers one video row at a time and emits it as an AXI INCR burst into a double-buffered frame store.
// Optional MEMORY_WRITER_TLAST_CHECK_EN adds a sticky err_tlast output flagging misplaced tlast.
module memory_writer
    import memory_writer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MAX_WIDTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BUF0_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] BUF1_ADDR  = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic [31:0]             pixels_per_frame,
    input  logic [15:0]             frame_height,
    input  logic [15:0]             frame_width,
    output logic                    start_write,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [31:0]             write_len,
    output logic [2:0]              write_size,
    output logic [1:0]              write_burst,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    frame_ready,
    output logic [ADDR_WIDTH-1:0]   base_addr_out
`ifdef MEMORY_WRITER_TLAST_CHECK_EN
    ,
    output logic                    err_tlast
`endif
);

    localparam int         LB_AW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [2:0] BEAT_SIZE = size_from_width(DATA_WIDTH);

    state_t                  state_reg, state_next;
    logic [15:0]             col_reg, col_next, row_reg, row_next, beat_reg, beat_next;
    logic [15:0]             width_reg, width_next, height_reg, height_next;
    logic                    buf_sel_reg, buf_sel_next;
    logic [ADDR_WIDTH-1:0]   line_addr_reg, line_addr_next;
    logic                    start_write_reg, start_write_next;
    logic [ADDR_WIDTH-1:0]   write_addr_reg, write_addr_next;
    logic [31:0]             write_len_reg, write_len_next;
    logic [2:0]              write_size_reg, write_size_next;
    logic [1:0]              write_burst_reg, write_burst_next;
    logic [DATA_WIDTH/8-1:0] strb_reg;
    logic                    frame_ready_reg, frame_ready_next;
    logic [ADDR_WIDTH-1:0]   base_out_reg, base_out_next;

    logic                    accept, take_sof, go_burst;
    logic [ADDR_WIDTH-1:0]   frame_base, stride, burst_addr;
    logic [15:0]             burst_width;
    logic                    wr_en, rd_en;
    logic [LB_AW-1:0]        wr_addr, rd_addr;

    assign s_axis_tready = ~rst & ((state_reg == IDLE) | (state_reg == FILL));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign frame_base    = buf_sel_reg ? BUF1_ADDR : BUF0_ADDR;
    assign stride        = ADDR_WIDTH'(width_reg) << BEAT_SIZE;

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        row_next         = row_reg;
        beat_next        = beat_reg;
        width_next       = width_reg;
        height_next      = height_reg;
        buf_sel_next     = buf_sel_reg;
        line_addr_next   = line_addr_reg;
        start_write_next = 1'b0;
        write_addr_next  = write_addr_reg;
        write_len_next   = write_len_reg;
        write_size_next  = write_size_reg;
        write_burst_next = write_burst_reg;
        frame_ready_next = 1'b0;
        base_out_next    = base_out_reg;
        wr_en            = 1'b0;
        wr_addr          = col_reg[LB_AW-1:0];
        rd_en            = 1'b0;
        rd_addr          = beat_reg[LB_AW-1:0];
        take_sof         = 1'b0;
        go_burst         = 1'b0;
        burst_addr       = line_addr_reg;
        burst_width      = width_reg;

        case (state_reg)
            IDLE: begin
                if (accept && s_axis_tuser) begin
                    take_sof = 1'b1;
                end
            end
            FILL: begin
                if (accept) begin
                    if (s_axis_tuser) begin
                        take_sof = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (col_reg == width_reg - 16'd1) begin
                            go_burst = 1'b1;
                        end else begin
                            col_next = col_reg + 16'd1;
                        end
                    end
                end
            end
            BURST: begin
                // beat 0 is the command cycle; the read issued on beat k lands on write_data at beat k+1
                rd_en     = (beat_reg < width_reg);
                beat_next = beat_reg + 16'd1;
                if (beat_reg == width_reg) begin
                    beat_next = 16'd0;
                    if (row_reg == height_reg - 16'd1) begin
                        state_next       = DONE;
                        frame_ready_next = 1'b1;
                        base_out_next    = frame_base;
                    end else begin
                        state_next     = FILL;
                        row_next       = row_reg + 16'd1;
                        line_addr_next = line_addr_reg + stride;
                    end
                end
            end
            DONE: begin
                state_next   = IDLE;
                buf_sel_next = ~buf_sel_reg;
                row_next     = 16'd0;
                col_next     = 16'd0;
            end
            default: state_next = IDLE;
        endcase

        // A start-of-frame beat restarts on the current buffer, even mid-row.
        if (take_sof) begin
            wr_en          = 1'b1;
            wr_addr        = '0;
            width_next     = frame_width;
            height_next    = frame_height;
            row_next       = 16'd0;
            line_addr_next = frame_base;
            burst_addr     = frame_base;
            burst_width    = frame_width;
            if (frame_width == 16'd1) begin
                go_burst = 1'b1;
            end else begin
                state_next = FILL;
                col_next   = 16'd1;
            end
        end

        if (go_burst) begin
            state_next       = BURST;
            col_next         = 16'd0;
            beat_next        = 16'd0;
            start_write_next = 1'b1;
            write_addr_next  = burst_addr;
            write_len_next   = 32'(burst_width) - 32'd1;
            write_size_next  = BEAT_SIZE;
            write_burst_next = BURST_INCR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            col_reg         <= '0;
            row_reg         <= '0;
            beat_reg        <= '0;
            width_reg       <= '0;
            height_reg      <= '0;
            buf_sel_reg     <= 1'b0;
            line_addr_reg   <= '0;
            start_write_reg <= 1'b0;
            write_addr_reg  <= '0;
            write_len_reg   <= '0;
            write_size_reg  <= '0;
            write_burst_reg <= '0;
            strb_reg        <= '0;
            frame_ready_reg <= 1'b0;
            base_out_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            row_reg         <= row_next;
            beat_reg        <= beat_next;
            width_reg       <= width_next;
            height_reg      <= height_next;
            buf_sel_reg     <= buf_sel_next;
            line_addr_reg   <= line_addr_next;
            start_write_reg <= start_write_next;
            write_addr_reg  <= write_addr_next;
            write_len_reg   <= write_len_next;
            write_size_reg  <= write_size_next;
            write_burst_reg <= write_burst_next;
            strb_reg        <= '1;
            frame_ready_reg <= frame_ready_next;
            base_out_reg    <= base_out_next;
        end
    end

    memory_writer_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH),
        .ADDR_BITS  (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (write_data)
    );

    assign start_write   = start_write_reg;
    assign write_addr    = write_addr_reg;
    assign write_len     = write_len_reg;
    assign write_size    = write_size_reg;
    assign write_burst   = write_burst_reg;
    assign write_strb    = strb_reg;
    assign frame_ready   = frame_ready_reg;
    assign base_addr_out = base_out_reg;

`ifdef MEMORY_WRITER_TLAST_CHECK_EN
    logic err_tlast_reg, beat_taken, last_expected;
    logic unused_cfg;

    always_comb begin
        beat_taken    = take_sof | ((state_reg == FILL) & accept);
        last_expected = take_sof ? (frame_width == 16'd1) : (col_reg == width_reg - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tlast_reg <= 1'b0;
        end else if (beat_taken && (s_axis_tlast != last_expected)) begin
            err_tlast_reg <= 1'b1;
        end
    end

    assign err_tlast  = err_tlast_reg;
    assign unused_cfg = ^pixels_per_frame;
`else
    // Row length comes from frame_width alone; tlast and the pixel count carry no extra information.
    logic unused_cfg;
    assign unused_cfg = ^{s_axis_tlast, pixels_per_frame};
`endif

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer: frame-level scoreboard of expected bursts, pixels and frame_ready.
module tb_memory_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0010_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [31:0]   pixels_per_frame = 32'd8;
    logic [15:0]   frame_height = 16'd2;
    logic [15:0]   frame_width = 16'd4;
    logic          start_write;
    logic [AW-1:0] write_addr;
    logic [31:0]   write_len;
    logic [2:0]    write_size;
    logic [1:0]    write_burst;
    logic [DW-1:0] write_data;
    logic [DW/8-1:0] write_strb;
    logic          frame_ready;
    logic [AW-1:0] base_addr_out;
`ifdef MEMORY_WRITER_TLAST_CHECK_EN
    logic          err_tlast;
`endif

    always #5 clk = ~clk;

    memory_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WIDTH  (1024),
        .BUF0_ADDR  (B0),
        .BUF1_ADDR  (B1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .pixels_per_frame (pixels_per_frame),
        .frame_height     (frame_height),
        .frame_width      (frame_width),
        .start_write      (start_write),
        .write_addr       (write_addr),
        .write_len        (write_len),
        .write_size       (write_size),
        .write_burst      (write_burst),
        .write_data       (write_data),
        .write_strb       (write_strb),
        .frame_ready      (frame_ready),
        .base_addr_out    (base_addr_out)
`ifdef MEMORY_WRITER_TLAST_CHECK_EN
        ,
        .err_tlast        (err_tlast)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    burst_t      exp_burst[$];
    logic [31:0] exp_pix[$];
    logic [31:0] exp_frame[$];
    logic [31:0] obs_addr[$], obs_len[$], obs_data[$], obs_base[$];
    burst_t      cur_b;
    int          n_checks = 0;
    int          n_fail = 0;
    int          data_left = 0;
    logic [31:0] model_base = B0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Compare process: every data beat, command and frame_ready against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_burst.delete();
            exp_pix.delete();
            data_left = 0;
        end else begin
            if (data_left > 0) begin
                obs_data.push_back(write_data);
                check("write_strb", 64'(write_strb), 64'hf);
                check("start_write_during_data", 64'(start_write), 64'd0);
                if (exp_pix.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_data: got %0h, required no beat", write_data);
                end else begin
                    check("write_data", 64'(write_data), 64'(exp_pix.pop_front()));
                end
                data_left--;
            end else if (start_write) begin
                $display("burst addr=%08h len=%0d size=%0d burst=%0d", write_addr, write_len, write_size, write_burst);
                obs_addr.push_back(write_addr);
                obs_len.push_back(write_len);
                if (exp_burst.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start_write: got addr %08h, required no burst", write_addr);
                end else begin
                    cur_b = exp_burst.pop_front();
                    check("write_addr", 64'(write_addr), 64'(cur_b.addr));
                    check("write_len", 64'(write_len), 64'(cur_b.len));
                    check("write_size", 64'(write_size), 64'd2);
                    check("write_burst", 64'(write_burst), 64'd1);
                    data_left = int'(cur_b.len) + 1;
                end
            end
            if (frame_ready) begin
                $display("frame_ready base=%08h", base_addr_out);
                obs_base.push_back(base_addr_out);
                if (exp_frame.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_ready: got base %08h, required none", base_addr_out);
                end else begin
                    check("base_addr_out", 64'(base_addr_out), 64'(exp_frame.pop_front()));
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL tready_timeout: got tready 0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Pixel i of the frame is first + i*step; rows land at base + row*w*4.
    task automatic send_frame(input int w, input int h, input logic [31:0] first, input logic [31:0] step,
                              input int gap_at, input bit complete, input int bad_last);
        burst_t nb;
        frame_width      = 16'(w);
        frame_height     = 16'(h);
        pixels_per_frame = 32'(w * h);
        for (int r = 0; r < h; r++) begin
            nb.addr = model_base + 32'(r * w * 4);
            nb.len  = 32'(w - 1);
            exp_burst.push_back(nb);
            for (int c = 0; c < w; c++) begin
                exp_pix.push_back(first + step * 32'(r * w + c));
            end
        end
        if (complete) begin
            exp_frame.push_back(model_base);
            model_base = (model_base == B0) ? B1 : B0;
        end
        for (int i = 0; i < w * h; i++) begin
            send_beat(first + step * 32'(i), (i == 0), ((i % w) == w - 1) || (i == bad_last));
            if (i == 0) begin
                frame_width  = 16'(w + 3);
                frame_height = 16'(h + 5);
            end
            if (i == gap_at) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        frame_width  = 16'(w);
        frame_height = 16'(h);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_burst.size() != 0 || exp_pix.size() != 0 || exp_frame.size() != 0 || data_left != 0) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_within_budget", 64'(g < 500), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_addr(input int idx, input logic [31:0] exp);
        check($sformatf("burst%0d_addr", idx), 64'((idx < obs_addr.size()) ? obs_addr[idx] : 'x), 64'(exp));
    endtask

    task automatic check_data(input int idx, input logic [31:0] exp);
        check($sformatf("beat%0d_data", idx), 64'((idx < obs_data.size()) ? obs_data[idx] : 'x), 64'(exp));
    endtask

    task automatic check_base(input int idx, input logic [31:0] exp);
        check($sformatf("frame%0d_base", idx), 64'((idx < obs_base.size()) ? obs_base[idx] : 'x), 64'(exp));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start_write"}, 64'(start_write), 64'd0);
        check({tag, "_frame_ready"}, 64'(frame_ready), 64'd0);
        check({tag, "_write_addr"}, 64'(write_addr), 64'd0);
        check({tag, "_write_len"}, 64'(write_len), 64'd0);
        check({tag, "_write_size"}, 64'(write_size), 64'd0);
        check({tag, "_write_burst"}, 64'(write_burst), 64'd0);
        check({tag, "_write_data"}, 64'(write_data), 64'd0);
        check({tag, "_write_strb"}, 64'(write_strb), 64'd0);
        check({tag, "_base_addr_out"}, 64'(base_addr_out), 64'd0);
        check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        #1;
        check("tready_after_reset", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // Beats before any start-of-frame are dropped.
        for (int k = 0; k < 3; k++) send_beat(32'hdead_0000 + 32'(k), 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("discard_no_burst", 64'(obs_addr.size()), 64'd0);

        // Frame A: 4x2, pixels i*100 into buffer 0.
        send_frame(4, 2, 32'd0, 32'd100, -1, 1'b1, -1);
        drain();
        check_addr(0, 32'h0000_0000);
        check_addr(1, 32'h0000_0010);
        check("burst0_len", 64'((obs_len.size() > 0) ? obs_len[0] : 'x), 64'd3);
        check_data(0, 32'd0);
        check_data(3, 32'd300);
        check_data(4, 32'd400);
        check_data(7, 32'd700);
        check_base(0, 32'h0000_0000);
        check("frameA_ready_count", 64'(obs_base.size()), 64'd1);

        // Frame B goes to buffer 1, frame C (with a tvalid gap) back to buffer 0.
        send_frame(4, 2, 32'd0, 32'd100, -1, 1'b1, -1);
        drain();
        check_addr(2, 32'h0010_0000);
        check_addr(3, 32'h0010_0010);
        check_base(1, 32'h0010_0000);
        send_frame(4, 2, 32'd0, 32'd100, 2, 1'b1, -1);
        drain();
        check_addr(4, 32'h0000_0000);
        check_addr(5, 32'h0000_0010);
        check_data(21, 32'd500);

        // tuser mid-row abandons the partial frame; the restart stays on buffer 1.
        frame_width  = 16'd4;
        frame_height = 16'd2;
        send_beat(32'd9000, 1'b1, 1'b0);
        send_beat(32'd9001, 1'b0, 1'b0);
        send_frame(4, 1, 32'd5000, 32'd1, -1, 1'b1, -1);
        drain();
        check_addr(6, 32'h0010_0000);
        check_data(24, 32'd5000);
        check_data(27, 32'd5003);
        check_base(3, 32'h0010_0000);

        // Single-pixel rows: zero-length bursts 4 bytes apart.
        send_frame(1, 3, 32'd42, 32'd1, -1, 1'b1, -1);
        drain();
        check_addr(7, 32'h0000_0000);
        check_addr(8, 32'h0000_0004);
        check_addr(9, 32'h0000_0008);
        check("burst7_len", 64'((obs_len.size() > 7) ? obs_len[7] : 'x), 64'd0);
        check_data(30, 32'd44);

        // Reset right after the row-1 command of a buffer-1 frame.
        send_frame(4, 2, 32'd7000, 32'd1, -1, 1'b0, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midburst_reset");
        model_base = B0;
        rst = 1'b0;
        #1;
        check("tready_after_midburst_reset", 64'(s_axis_tready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check_addr(11, 32'h0010_0010);
        check("aborted_no_frame_ready", 64'(obs_base.size()), 64'd5);
        send_frame(4, 2, 32'd0, 32'd100, -1, 1'b1, -1);
        drain();
        check_addr(12, 32'h0000_0000);
        check_addr(13, 32'h0000_0010);
        check_base(5, 32'h0000_0000);

`ifdef MEMORY_WRITER_TLAST_CHECK_EN
        check("err_tlast_clean", 64'(err_tlast), 64'd0);
        send_frame(4, 1, 32'd1, 32'd1, -1, 1'b1, 2);
        drain();
        check("err_tlast_set", 64'(err_tlast), 64'd1);
        send_frame(4, 1, 32'd1, 32'd1, -1, 1'b1, -1);
        drain();
        check("err_tlast_sticky", 64'(err_tlast), 64'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("err_tlast_reset", 64'(err_tlast), 64'd0);
        rst = 1'b0;
        model_base = B0;
        @(posedge clk);
        #1;
`endif

        check("scoreboard_empty", 64'(exp_burst.size() + exp_pix.size() + exp_frame.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
